// File: rtl/food_coord_rng.sv
// food_coord_rng: two-channel (X/Y) Fibonacci LFSR coordinate generator for snake food placement.
// Each request is answered with an in-range coordinate chosen by rejection sampling.
// If no candidate is accepted within MAX_TRIES evaluations, a deterministic fallback is returned.
// One cell (e.g. the snake head) can optionally be excluded.

module food_coord_rng #(
  parameter int unsigned       WIDTH     = 10,
  parameter logic [WIDTH-1:0]  TAPS      = 10'h240,
  parameter logic [WIDTH-1:0]  SEED_X    = 10'h00F,
  parameter logic [WIDTH-1:0]  SEED_Y    = 10'h0F0,
  parameter int unsigned       COORD_W   = 6,
  parameter int unsigned       X_MAX     = 64,
  parameter int unsigned       Y_MAX     = 48,
  parameter int unsigned       MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_x,
  input  logic [WIDTH-1:0]   seed_y,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               avoid_en,
  input  logic [COORD_W-1:0] avoid_x,
  input  logic [COORD_W-1:0] avoid_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [COORD_W-1:0] rsp_x,
  output logic [COORD_W-1:0] rsp_y,
  output logic               rsp_fallback,
  output logic [WIDTH-1:0]   lfsr_x,
  output logic [WIDTH-1:0]   lfsr_y
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DRAW = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  // Range limits need one extra bit: X_MAX may equal 2^COORD_W.
  localparam logic [COORD_W:0]   X_LIM  = (COORD_W + 1)'(X_MAX);
  localparam logic [COORD_W:0]   Y_LIM  = (COORD_W + 1)'(Y_MAX);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_MAX - 1);

  // Fibonacci step with lockup recovery: an all-zero state jumps back to the default seed.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] state,
                                                 input logic [WIDTH-1:0] dflt);
    if (state == '0) begin
      return dflt;
    end
    return {state[WIDTH-2:0], ^(state & TAPS)};
  endfunction

  logic [1:0]         r_state;
  logic [TRY_W-1:0]   r_tries;
  logic [WIDTH-1:0]   r_lfsr_x;
  logic [WIDTH-1:0]   r_lfsr_y;
  logic [COORD_W-1:0] r_rsp_x;
  logic [COORD_W-1:0] r_rsp_y;
  logic               r_rsp_fb;

  logic [1:0]         w_state_nxt;
  logic [TRY_W-1:0]   w_tries_nxt;
  logic [COORD_W-1:0] w_rsp_x_nxt;
  logic [COORD_W-1:0] w_rsp_y_nxt;
  logic               w_rsp_fb_nxt;
  logic [WIDTH-1:0]   w_lfsr_x_nxt;
  logic [WIDTH-1:0]   w_lfsr_y_nxt;

  logic               w_step;
  logic [WIDTH-1:0]   w_seed_x;
  logic [WIDTH-1:0]   w_seed_y;
  logic [COORD_W-1:0] w_cx;
  logic [COORD_W-1:0] w_cy;
  logic               w_x_ok;
  logic               w_y_ok;
  logic               w_hit;
  logic               w_accept;
  logic               w_last;
  logic [COORD_W-1:0] w_fx_wrap;
  logic [COORD_W-1:0] w_fy_wrap;
  logic               w_fb_hit;
  logic [COORD_W-1:0] w_fx;

  // DRAW forces stepping so that every rejected candidate is followed by a fresh one.
  assign w_step   = enable | (r_state == ST_DRAW);
  assign w_seed_x = (seed_x == '0) ? SEED_X : seed_x;
  assign w_seed_y = (seed_y == '0) ? SEED_Y : seed_y;

  // Candidate evaluation on the current-cycle LFSR state.
  assign w_cx     = r_lfsr_x[COORD_W-1:0];
  assign w_cy     = r_lfsr_y[COORD_W-1:0];
  assign w_x_ok   = {1'b0, w_cx} < X_LIM;
  assign w_y_ok   = {1'b0, w_cy} < Y_LIM;
  assign w_hit    = avoid_en & (w_cx == avoid_x) & (w_cy == avoid_y);
  assign w_accept = w_x_ok & w_y_ok & ~w_hit;
  assign w_last   = (r_tries == LAST_TRY);

  // Fallback: a single subtraction folds the candidate into range because MAX >= 2^(COORD_W-1).
  assign w_fx_wrap = w_x_ok ? w_cx : COORD_W'({1'b0, w_cx} - X_LIM);
  assign w_fy_wrap = w_y_ok ? w_cy : COORD_W'({1'b0, w_cy} - Y_LIM);
  assign w_fb_hit  = avoid_en & (w_fx_wrap == avoid_x) & (w_fy_wrap == avoid_y);
  // Step off the excluded cell along X, wrapping at the right edge.
  assign w_fx      = !w_fb_hit ? w_fx_wrap :
                     (w_fx_wrap == X_LAST) ? '0 : w_fx_wrap + 1'b1;

  // Request/response FSM next-state and response latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_tries_nxt  = r_tries;
    w_rsp_x_nxt  = r_rsp_x;
    w_rsp_y_nxt  = r_rsp_y;
    w_rsp_fb_nxt = r_rsp_fb;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_state_nxt = ST_DRAW;
          w_tries_nxt = '0;
        end
      end
      ST_DRAW: begin
        if (w_accept) begin
          w_rsp_x_nxt  = w_cx;
          w_rsp_y_nxt  = w_cy;
          w_rsp_fb_nxt = 1'b0;
          w_state_nxt  = ST_HOLD;
        end else if (w_last) begin
          w_rsp_x_nxt  = w_fx;
          w_rsp_y_nxt  = w_fy_wrap;
          w_rsp_fb_nxt = 1'b1;
          w_state_nxt  = ST_HOLD;
        end else begin
          w_tries_nxt = r_tries + 1'b1;
        end
      end
      ST_HOLD: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // LFSR next state: seed load beats stepping, stepping beats hold.
  always_comb begin
    w_lfsr_x_nxt = r_lfsr_x;
    w_lfsr_y_nxt = r_lfsr_y;
    if (seed_load) begin
      w_lfsr_x_nxt = w_seed_x;
      w_lfsr_y_nxt = w_seed_y;
    end else if (w_step) begin
      w_lfsr_x_nxt = lfsr_next(r_lfsr_x, SEED_X);
      w_lfsr_y_nxt = lfsr_next(r_lfsr_y, SEED_Y);
    end
  end

  // FSM, retry counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_tries  <= '0;
      r_rsp_x  <= '0;
      r_rsp_y  <= '0;
      r_rsp_fb <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tries  <= w_tries_nxt;
      r_rsp_x  <= w_rsp_x_nxt;
      r_rsp_y  <= w_rsp_y_nxt;
      r_rsp_fb <= w_rsp_fb_nxt;
    end
  end

  // LFSR state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr_x <= SEED_X;
      r_lfsr_y <= SEED_Y;
    end else begin
      r_lfsr_x <= w_lfsr_x_nxt;
      r_lfsr_y <= w_lfsr_y_nxt;
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign rsp_valid    = (r_state == ST_HOLD);
  assign rsp_x        = r_rsp_x;
  assign rsp_y        = r_rsp_y;
  assign rsp_fallback = r_rsp_fb;
  assign lfsr_x       = r_lfsr_x;
  assign lfsr_y       = r_lfsr_y;

endmodule

// File: tb/tb_food_coord_rng.sv
// Bench for food_coord_rng: directed vector table, hand-written corner sequences,
// and a randomised run against a behavioural model (two DUTs: MAX_TRIES=8 and MAX_TRIES=1).

module tb_food_coord_rng;

  localparam int XM = 64;
  localparam int YM = 48;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       seed_load;
  logic [9:0] seed_x;
  logic [9:0] seed_y;
  logic       req_valid;
  logic       avoid_en;
  logic [5:0] avoid_x;
  logic [5:0] avoid_y;
  logic       rsp_ready;

  logic       d0_req_ready, d0_rsp_valid, d0_rsp_fb;
  logic [5:0] d0_rsp_x, d0_rsp_y;
  logic [9:0] d0_lfsr_x, d0_lfsr_y;
  logic       d1_req_ready, d1_rsp_valid, d1_rsp_fb;
  logic [5:0] d1_rsp_x, d1_rsp_y;
  logic [9:0] d1_lfsr_x, d1_lfsr_y;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  food_coord_rng #(.MAX_TRIES(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
    .seed_x(seed_x), .seed_y(seed_y), .req_valid(req_valid), .req_ready(d0_req_ready),
    .avoid_en(avoid_en), .avoid_x(avoid_x), .avoid_y(avoid_y),
    .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready), .rsp_x(d0_rsp_x), .rsp_y(d0_rsp_y),
    .rsp_fallback(d0_rsp_fb), .lfsr_x(d0_lfsr_x), .lfsr_y(d0_lfsr_y)
  );

  food_coord_rng #(.MAX_TRIES(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
    .seed_x(seed_x), .seed_y(seed_y), .req_valid(req_valid), .req_ready(d1_req_ready),
    .avoid_en(avoid_en), .avoid_x(avoid_x), .avoid_y(avoid_y),
    .rsp_valid(d1_rsp_valid), .rsp_ready(rsp_ready), .rsp_x(d1_rsp_x), .rsp_y(d1_rsp_y),
    .rsp_fallback(d1_rsp_fb), .lfsr_x(d1_lfsr_x), .lfsr_y(d1_lfsr_y)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int lx, ly, st, tries, rx, ry, fb;
  } model_t;

  model_t m0, m1;

  function automatic int lstep(input int s, input int dflt);
    if (s == 0) return dflt;
    return ((s << 1) & 'h3FF) | ($countones(s & 'h240) & 1);
  endfunction

  // st: 0 idle, 1 draw, 2 hold
  function automatic model_t mnext(input model_t m, input int max_tries);
    model_t n;
    int cx, cy, fx, fy;
    bit stp;
    n = m;
    if (rst) begin
      n.lx = 'h00F; n.ly = 'h0F0; n.st = 0; n.tries = 0; n.rx = 0; n.ry = 0; n.fb = 0;
      return n;
    end
    stp = enable || (m.st == 1);
    if (m.st == 0) begin
      if (req_valid) begin n.st = 1; n.tries = 0; end
    end else if (m.st == 1) begin
      cx = m.lx % 64;
      cy = m.ly % 64;
      if (cx < XM && cy < YM && !(avoid_en && cx == int'(avoid_x) && cy == int'(avoid_y))) begin
        n.rx = cx; n.ry = cy; n.fb = 0; n.st = 2;
      end else if (m.tries == max_tries - 1) begin
        fx = cx % XM;
        fy = cy % YM;
        if (avoid_en && fx == int'(avoid_x) && fy == int'(avoid_y)) fx = (fx + 1) % XM;
        n.rx = fx; n.ry = fy; n.fb = 1; n.st = 2;
      end else begin
        n.tries = m.tries + 1;
      end
    end else begin
      if (rsp_ready) n.st = 0;
    end
    if (seed_load) begin
      n.lx = (seed_x == 0) ? 'h00F : int'(seed_x);
      n.ly = (seed_y == 0) ? 'h0F0 : int'(seed_y);
    end else if (stp) begin
      n.lx = lstep(m.lx, 'h00F);
      n.ly = lstep(m.ly, 'h0F0);
    end
    return n;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m0 = mnext(m0, 8);
    m1 = mnext(m1, 1);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; enable = 0; seed_load = 0; seed_x = 0; seed_y = 0; req_valid = 0;
    avoid_en = 0; avoid_x = 0; avoid_y = 0; rsp_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " d0 lfsr_x"}, d0_lfsr_x, m0.lx);
    chk({tag, " d0 lfsr_y"}, d0_lfsr_y, m0.ly);
    chk({tag, " d0 req_ready"}, d0_req_ready, m0.st == 0);
    chk({tag, " d0 rsp_valid"}, d0_rsp_valid, m0.st == 2);
    chk({tag, " d0 rsp_x"}, d0_rsp_x, m0.rx);
    chk({tag, " d0 rsp_y"}, d0_rsp_y, m0.ry);
    chk({tag, " d0 rsp_fb"}, d0_rsp_fb, m0.fb);
    chk({tag, " d1 lfsr_x"}, d1_lfsr_x, m1.lx);
    chk({tag, " d1 lfsr_y"}, d1_lfsr_y, m1.ly);
    chk({tag, " d1 req_ready"}, d1_req_ready, m1.st == 0);
    chk({tag, " d1 rsp_valid"}, d1_rsp_valid, m1.st == 2);
    chk({tag, " d1 rsp_x"}, d1_rsp_x, m1.rx);
    chk({tag, " d1 rsp_y"}, d1_rsp_y, m1.ry);
    chk({tag, " d1 rsp_fb"}, d1_rsp_fb, m1.fb);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       en, sl;
    logic [9:0] sx, sy;
    logic       rq, rr, ae;
    logic [5:0] ax, ay;
    logic [9:0] elx, ely;
    logic       erdy, evld, chk_rsp;
    logic [5:0] erx, ery;
    logic       efb;
  } vec_t;

  vec_t vec[21];

  initial begin
    int first_ret;
    bit zero_seen;
    logic [5:0] prev_x, prev_y;
    logic prev_stall;

    // en sl  sx     sy   rq rr ae ax ay   lfsr_x lfsr_y rdy vld chk rx ry fb
    vec[0]  = '{1, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 10'h01E, 10'h1E1, 1, 0, 0, 0, 0, 0};
    vec[1]  = '{1, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 10'h03C, 10'h3C3, 1, 0, 0, 0, 0, 0};
    vec[2]  = '{1, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 10'h078, 10'h386, 1, 0, 0, 0, 0, 0};
    vec[3]  = '{1, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 10'h0F1, 10'h30D, 1, 0, 0, 0, 0, 0};
    vec[4]  = '{0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 10'h0F1, 10'h30D, 1, 0, 0, 0, 0, 0};
    vec[5]  = '{1, 1, 10'h000, 10'h000, 0, 0, 0, 0, 0, 10'h00F, 10'h0F0, 1, 0, 0, 0, 0, 0};
    vec[6]  = '{0, 1, 10'h005, 10'h003, 0, 0, 0, 0, 0, 10'h005, 10'h003, 1, 0, 0, 0, 0, 0};
    vec[7]  = '{0, 0, 10'h000, 10'h000, 1, 0, 0, 0, 0, 10'h005, 10'h003, 0, 0, 0, 0, 0, 0};
    vec[8]  = '{0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 10'h00A, 10'h006, 0, 1, 1, 5, 3, 0};
    vec[9]  = '{0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 10'h00A, 10'h006, 0, 1, 1, 5, 3, 0};
    vec[10] = '{0, 0, 10'h000, 10'h000, 0, 1, 0, 0, 0, 10'h00A, 10'h006, 1, 0, 0, 0, 0, 0};
    vec[11] = '{0, 1, 10'h005, 10'h003, 0, 0, 0, 0, 0, 10'h005, 10'h003, 1, 0, 0, 0, 0, 0};
    vec[12] = '{0, 0, 10'h000, 10'h000, 1, 0, 1, 5, 3, 10'h005, 10'h003, 0, 0, 0, 0, 0, 0};
    vec[13] = '{0, 0, 10'h000, 10'h000, 0, 0, 1, 5, 3, 10'h00A, 10'h006, 0, 0, 0, 0, 0, 0};
    vec[14] = '{0, 0, 10'h000, 10'h000, 0, 0, 1, 5, 3, 10'h014, 10'h00C, 0, 1, 1, 10, 6, 0};
    vec[15] = '{0, 0, 10'h000, 10'h000, 0, 1, 0, 0, 0, 10'h014, 10'h00C, 1, 0, 0, 0, 0, 0};
    vec[16] = '{0, 1, 10'h005, 10'h030, 0, 0, 0, 0, 0, 10'h005, 10'h030, 1, 0, 0, 0, 0, 0};
    vec[17] = '{0, 0, 10'h000, 10'h000, 1, 0, 0, 0, 0, 10'h005, 10'h030, 0, 0, 0, 0, 0, 0};
    vec[18] = '{0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 10'h00A, 10'h060, 0, 0, 0, 0, 0, 0};
    vec[19] = '{0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 10'h014, 10'h0C1, 0, 1, 1, 10, 32, 0};
    vec[20] = '{0, 0, 10'h000, 10'h000, 0, 1, 0, 0, 0, 10'h014, 10'h0C1, 1, 0, 0, 0, 0, 0};

    // Reset state
    do_reset();
    chk("reset lfsr_x", d0_lfsr_x, 'h00F);
    chk("reset lfsr_y", d0_lfsr_y, 'h0F0);
    chk("reset req_ready", d0_req_ready, 1);
    chk("reset rsp_valid", d0_rsp_valid, 0);
    chk("reset rsp_x", d0_rsp_x, 0);
    chk("reset rsp_y", d0_rsp_y, 0);
    chk("reset rsp_fb", d0_rsp_fb, 0);

    foreach (vec[i]) begin
      enable = vec[i].en; seed_load = vec[i].sl; seed_x = vec[i].sx; seed_y = vec[i].sy;
      req_valid = vec[i].rq; rsp_ready = vec[i].rr; avoid_en = vec[i].ae;
      avoid_x = vec[i].ax; avoid_y = vec[i].ay;
      tick();
      chk($sformatf("vec%0d lfsr_x", i), d0_lfsr_x, vec[i].elx);
      chk($sformatf("vec%0d lfsr_y", i), d0_lfsr_y, vec[i].ely);
      chk($sformatf("vec%0d req_ready", i), d0_req_ready, vec[i].erdy);
      chk($sformatf("vec%0d rsp_valid", i), d0_rsp_valid, vec[i].evld);
      if (vec[i].chk_rsp) begin
        chk($sformatf("vec%0d rsp_x", i), d0_rsp_x, vec[i].erx);
        chk($sformatf("vec%0d rsp_y", i), d0_rsp_y, vec[i].ery);
        chk($sformatf("vec%0d rsp_fb", i), d0_rsp_fb, vec[i].efb);
      end
    end

    // Full period of the default polynomial; zero never appears
    do_reset();
    enable = 1;
    first_ret = 0;
    zero_seen = 0;
    for (int i = 1; i <= 1023; i++) begin
      tick();
      if (d0_lfsr_x == 0) zero_seen = 1;
      if (first_ret == 0 && d0_lfsr_x == 10'h00F) first_ret = i;
    end
    chk("period first return", first_ret, 1023);
    chk("period zero seen", zero_seen, 0);
    chk("period lfsr_y back", d0_lfsr_y, 'h0F0);

    // Fallback on Y out of range (MAX_TRIES=1): 63-48 = 15
    do_reset();
    seed_load = 1; seed_x = 10'h005; seed_y = 10'h03F;
    tick();
    seed_load = 0; req_valid = 1;
    tick();
    req_valid = 0;
    tick();
    chk("fbY d1 rsp_valid", d1_rsp_valid, 1);
    chk("fbY d1 rsp_x", d1_rsp_x, 5);
    chk("fbY d1 rsp_y", d1_rsp_y, 15);
    chk("fbY d1 rsp_fb", d1_rsp_fb, 1);
    chk("fbY d0 still drawing", d0_rsp_valid, 0);
    rsp_ready = 1;
    tick();
    chk("fbY d1 back idle", d1_req_ready, 1);

    // Fallback on excluded cell: 5/3 -> 6/3
    do_reset();
    seed_load = 1; seed_x = 10'h005; seed_y = 10'h003;
    tick();
    seed_load = 0; req_valid = 1; avoid_en = 1; avoid_x = 5; avoid_y = 3;
    tick();
    req_valid = 0;
    tick();
    chk("fbA d1 rsp_x", d1_rsp_x, 6);
    chk("fbA d1 rsp_y", d1_rsp_y, 3);
    chk("fbA d1 rsp_fb", d1_rsp_fb, 1);

    // Excluded cell at right edge wraps X to 0
    do_reset();
    seed_load = 1; seed_x = 10'h03F; seed_y = 10'h003;
    tick();
    seed_load = 0; req_valid = 1; avoid_en = 1; avoid_x = 63; avoid_y = 3;
    tick();
    req_valid = 0;
    tick();
    chk("fbW d1 rsp_x", d1_rsp_x, 0);
    chk("fbW d1 rsp_y", d1_rsp_y, 3);
    chk("fbW d1 rsp_fb", d1_rsp_fb, 1);

    // Reset in the middle of DRAW drops the request
    do_reset();
    seed_load = 1; seed_x = 10'h005; seed_y = 10'h030;
    tick();
    seed_load = 0; req_valid = 1;
    tick();
    req_valid = 0;
    chk("midrst in draw", d0_req_ready, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst req_ready", d0_req_ready, 1);
    chk("midrst rsp_valid", d0_rsp_valid, 0);
    chk("midrst lfsr_x", d0_lfsr_x, 'h00F);
    tick();
    tick();
    chk("midrst no late rsp", d0_rsp_valid, 0);

    // Randomised run against the model
    do_reset();
    begin
      bit chase = 0;
      prev_stall = 0; prev_x = 0; prev_y = 0;
      for (int c = 0; c < 800; c++) begin
        rst       = ($urandom_range(0, 59) == 0);
        seed_load = ($urandom_range(0, 24) == 0);
        seed_x    = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom);
        seed_y    = ($urandom_range(0, 3) == 0) ? 10'h000 : 10'($urandom);
        enable    = 1'($urandom_range(0, 1));
        req_valid = ($urandom_range(0, 2) != 0);
        rsp_ready = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 15) == 0) chase = ~chase;
        avoid_en  = chase ? 1'b1 : 1'($urandom_range(0, 1));
        // In chase mode the excluded cell tracks the current candidate, forcing rejections.
        avoid_x   = chase ? 6'(m0.lx) : 6'($urandom);
        avoid_y   = chase ? 6'(m0.ly) : 6'($urandom);
        tick();
        chk_model($sformatf("rnd%0d", c));
        if (d0_rsp_valid) begin
          chk($sformatf("rnd%0d d0 x range", c), d0_rsp_x < XM, 1);
          chk($sformatf("rnd%0d d0 y range", c), d0_rsp_y < YM, 1);
          if (prev_stall) begin
            chk($sformatf("rnd%0d d0 stall x", c), d0_rsp_x, prev_x);
            chk($sformatf("rnd%0d d0 stall y", c), d0_rsp_y, prev_y);
          end
        end
        prev_stall = d0_rsp_valid && !rsp_ready && !rst;
        prev_x = d0_rsp_x;
        prev_y = d0_rsp_y;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
